wave_generator_nco: RTL and testbench

Parametrised numerically-controlled wave generator, successor to the single-mode sine generator. On each accepted request strobe it advances a wrapping phase accumulator by `phase_i` and produces one output sample. The sample is one of four selectable waveforms, computed by an in-block iterative CORDIC and scaled by `amplitude_i`. It sits between the sample-rate strobe source and the output/DAC formatting stage, and adds cosine, square and sawtooth modes, busy/overrun status, phase clear and configurable precision.

---
 rtl/wave_generator_nco.sv | 115 +++++++++++
 tb/tb_wave_generator_nco.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wave_generator_nco.sv
// wave_generator_nco: strobe-driven NCO producing sine, cosine, square or sawtooth samples
// from a wrapping phase accumulator through an iterative CORDIC, scaled by a snapshotted amplitude.
module wave_generator_nco #(
  parameter int N_FRAC = 7,
  parameter int N_ITER = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic signed [N_FRAC:0] phase_i,
  input  logic signed [N_FRAC:0] amplitude_i,
  input  logic [1:0]             mode_i,
  input  logic                   phase_clear_i,
  input  logic                   next_data_strobe_i,
  output logic signed [N_FRAC:0] data_o,
  output logic                   data_out_valid_strobe_o,
  output logic                   busy_o,
  output logic                   overrun_o
);
  localparam int W  = N_FRAC + 1;
  localparam int XW = N_FRAC + 3;
  localparam int ZW = N_FRAC + 2;
  localparam int CW = $clog2(N_ITER);
  localparam int K  = $rtoi(0.607253 * (2.0 ** N_FRAC) + 0.5);
  localparam logic signed [2*W:0]  KC   = (2*W+1)'(K);
  localparam logic signed [XW-1:0] DMAX = XW'((1 << N_FRAC) - 1);
  localparam logic signed [XW-1:0] DMIN = XW'(-(1 << N_FRAC));

  typedef enum logic [1:0] {IDLE, LOAD, ITER, OUT} state_t;

  function automatic int atan_lsb(input int i);
    return $rtoi($atan(2.0 ** (-i)) / 3.141592653589793 * (2.0 ** N_FRAC) + 0.5);
  endfunction

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           mode_q;
  logic signed [W-1:0]  acc_q, amp_q, data_q, acc_d, data_d;
  logic signed [XW-1:0] x_q, y_q, x_d, y_d, x0_d, amp_s, r;
  logic signed [ZW-1:0] z_q, z_d, z0_d;
  logic                 valid_q, overrun_q, flip;
  logic signed [ZW-1:0] atan_t [N_ITER];

  for (genvar g = 0; g < N_ITER; g++) begin : g_tab
    localparam int T = atan_lsb(g);
    assign atan_t[g] = ZW'(T);
  end

  // Phases beyond +-0.5 start from the negated vector so the CORDIC only has to cover +-pi/2.
  always_comb begin
    acc_d  = phase_clear_i ? phase_i : acc_q + phase_i;
    amp_s  = XW'(((2*W+1)'(amp_q) * KC) >>> N_FRAC);
    flip   = acc_q[W-1] ^ acc_q[W-2];
    x0_d   = flip ? -amp_s : amp_s;
    z0_d   = ZW'($signed({acc_q[W-1] ^ flip, acc_q[W-2:0]}));
    x_d    = z_q[ZW-1] ? x_q + (y_q >>> cnt_q) : x_q - (y_q >>> cnt_q);
    y_d    = z_q[ZW-1] ? y_q - (x_q >>> cnt_q) : y_q + (x_q >>> cnt_q);
    z_d    = z_q[ZW-1] ? z_q + atan_t[cnt_q] : z_q - atan_t[cnt_q];
    r      = mode_q == 2'd0 ? y_q :
             mode_q == 2'd1 ? x_q :
             mode_q == 2'd2 ? (acc_q[W-1] ? -XW'(amp_q) : XW'(amp_q)) :
             XW'(((2*W)'(acc_q) * (2*W)'(amp_q)) >>> N_FRAC);
    data_d = r > DMAX ? W'(DMAX) : r < DMIN ? W'(DMIN) : W'(r);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      acc_q     <= '0;
      amp_q     <= '0;
      data_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (next_data_strobe_i && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (next_data_strobe_i) begin
          acc_q   <= acc_d;
          amp_q   <= amplitude_i;
          mode_q  <= mode_i;
          state_q <= LOAD;
        end
        LOAD: begin
          x_q     <= x0_d;
          y_q     <= '0;
          z_q     <= z0_d;
          cnt_q   <= '0;
          state_q <= ITER;
        end
        ITER: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N_ITER - 1)) state_q <= OUT;
        end
        OUT: begin
          data_q  <= data_d;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_o                  = data_q;
  assign data_out_valid_strobe_o = valid_q;
  assign busy_o                  = state_q != IDLE;
  assign overrun_o               = overrun_q;
endmodule

// File: tb/tb_wave_generator_nco.sv
// tb_wave_generator_nco: directed and randomized samples checked against an ideal
// trigonometric/arithmetic model of the wave generator.
module tb_wave_generator_nco;
  localparam int NF  = 7;
  localparam int NI  = 8;
  localparam int LAT = NI + 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [NF:0]  phase = '0;
  logic signed [NF:0]  amp = '0;
  logic signed [NF:0]  data;
  logic [1:0]          mode = '0;
  logic                clr = 1'b0;
  logic                strobe = 1'b0;
  logic                valid, busy, overrun;
  int                  n_pass = 0;
  int                  n_chk = 0;
  int                  acc_m = 0;
  int                  last_busy = 0;
  int                  pulses, got;

  wave_generator_nco #(.N_FRAC(NF), .N_ITER(NI)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst_n),
    .phase_i                 (phase),
    .amplitude_i             (amp),
    .mode_i                  (mode),
    .phase_clear_i           (clr),
    .next_data_strobe_i      (strobe),
    .data_o                  (data),
    .data_out_valid_strobe_o (valid),
    .busy_o                  (busy),
    .overrun_o               (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    assert (obs >= exp - tol && obs <= exp + tol) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (tolerance %0d)", tag, obs, exp, tol);
  endtask

  function automatic int clip(input int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction

  function automatic int wrap(input int v);
    return ((v + 128) & 255) - 128;
  endfunction

  // Ideal waveform value for an accumulator in units of pi/128.
  function automatic int ref_sample(input int acc, input int a, input int md);
    real th;
    th = 3.141592653589793 * acc / 128.0;
    case (md)
      0:       return clip($rtoi($floor(a * $sin(th) + 0.5)));
      1:       return clip($rtoi($floor(a * $cos(th) + 0.5)));
      2:       return clip(acc >= 0 ? a : -a);
      default: return clip($rtoi($floor((acc * a) / 128.0)));
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where the valid pulse is seen.
  task automatic do_sample(input int ph, input int a, input int md, input bit pc, input int tol, input string tag);
    int n = 0;
    int b = 0;
    int expv;
    phase = 8'(ph); amp = 8'(a); mode = 2'(md); clr = pc; strobe = 1'b1;
    acc_m = pc ? wrap(ph) : wrap(acc_m + ph);
    expv = ref_sample(acc_m, a, md);
    @(posedge clk); #1;
    strobe = 1'b0;
    phase = 8'($urandom); amp = 8'($urandom); mode = 2'($urandom); clr = 1'($urandom);
    do begin
      @(negedge clk);
      n++;
      b += int'(busy);
    end while (!valid && n < 40);
    last_busy = b;
    check({tag, " latency"}, n - 1, LAT, 0);
    check({tag, " data"}, int'(data), expv, tol);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("reset data", int'(data), 0, 0);
    check("reset valid", int'(valid), 0, 0);
    check("reset busy", int'(busy), 0, 0);
    check("reset overrun", int'(overrun), 0, 0);
    rst_n = 1'b1;

    do_sample(64, 127, 0, 0, 2, "sine pi/2");
    check("busy cycles", last_busy, LAT, 0);
    @(negedge clk);
    check("valid width", int'(valid), 0, 0);

    for (int i = 0; i < 8; i++) do_sample(32, 127, 0, i == 0, 2, $sformatf("sweep %0d", i));

    do_sample(0, 127, 1, 0, 2, "cosine 0");
    do_sample(64, 127, 2, 0, 0, "square pos");
    do_sample(64, 127, 2, 0, 0, "square neg");
    do_sample(0, -128, 2, 0, 0, "square sat");
    do_sample(64, 127, 3, 1, 0, "saw half");
    do_sample(-128, 127, 3, 1, 0, "saw minus one");

    check("overrun before", int'(overrun), 0, 0);
    phase = 8'(32); amp = 8'(127); mode = 2'd0; clr = 1'b1; strobe = 1'b1;
    acc_m = 32;
    @(negedge clk); strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    phase = 8'(64); clr = 1'b0; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    check("overrun set", int'(overrun), 1, 0);
    pulses = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        got = int'(data);
      end
    end
    check("overrun pulses", pulses, 1, 0);
    check("overrun data", got, ref_sample(32, 127, 0), 2);
    check("overrun sticky", int'(overrun), 1, 0);
    do_sample(32, 127, 0, 0, 2, "after overrun");

    // Ideal-model tolerance is wider here: an 8-step CORDIC with a 7-bit angle table drifts off the exact curve.
    for (int i = 0; i < 12; i++) begin
      int md;
      md = int'($urandom_range(3));
      do_sample(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, md,
                $urandom_range(3) == 0, md < 2 ? 8 : 0, $sformatf("random %0d", i));
    end

    @(negedge clk);
    phase = 8'(64); amp = 8'(127); mode = 2'd0; clr = 1'b0; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset data", int'(data), 0, 0);
    check("midreset valid", int'(valid), 0, 0);
    check("midreset busy", int'(busy), 0, 0);
    check("midreset overrun", int'(overrun), 0, 0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("no pulse after reset", pulses, 0, 0);
    acc_m = 0;
    do_sample(64, 127, 0, 0, 2, "post-reset sine");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
